// File: rtl/aline_sequencer.sv
// A-line sequencer: walks a host-written per-channel delay table line by line,
// handing each delay set to transmit_fsm and pacing transmit / listen windows.
module aline_sequencer #(
  parameter int unsigned num_channels   = 8,
  parameter int unsigned count_num_bits = 16,
  parameter int unsigned num_alines     = 64,
  parameter int unsigned aline_bits     = 6,
  parameter int unsigned listen_bits    = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tbl_wr_en,
  input  logic [aline_bits-1:0]     tbl_wr_aline,
  input  logic [2:0]                tbl_wr_ch,
  input  logic [count_num_bits-1:0] tbl_wr_data,
  input  logic                      start_frame,
  input  logic                      abort,
  input  logic [aline_bits-1:0]     num_lines_m1,
  input  logic [listen_bits-1:0]    listen_cycles,
  input  logic                      transmit_complete,
  output logic [count_num_bits-1:0] delay_ch0,
  output logic [count_num_bits-1:0] delay_ch1,
  output logic [count_num_bits-1:0] delay_ch2,
  output logic [count_num_bits-1:0] delay_ch3,
  output logic [count_num_bits-1:0] delay_ch4,
  output logic [count_num_bits-1:0] delay_ch5,
  output logic [count_num_bits-1:0] delay_ch6,
  output logic [count_num_bits-1:0] delay_ch7,
  output logic                      input_delay_data,
  output logic                      start_transmit,
  output logic                      next_aline,
  output logic [aline_bits-1:0]     aline_index,
  output logic                      listening,
  output logic                      frame_busy,
  output logic                      frame_done
);

  localparam logic [3:0]             load_last   = 4'(num_channels);
  localparam logic [3:0]             settle_last = 4'd2;
  localparam logic [3:0]             step_one    = 4'd1;
  localparam logic [aline_bits-1:0]  aline_one   = 1;
  localparam logic [listen_bits-1:0] listen_one  = 1;

  typedef enum logic [3:0] {
    IDLE, LOAD, REQ, SETTLE, FIRE, WAIT_TX, LISTEN, NEXT, DONE
  } state_t;

  state_t state, state_d;

  logic [3:0]                step_cnt;
  logic [listen_bits-1:0]    listen_cnt;
  logic [count_num_bits-1:0] mem [0:num_alines*num_channels-1];
  logic [count_num_bits-1:0] rd_q;
  logic [count_num_bits-1:0] delay_q [8];
  logic [aline_bits+2:0]     rd_addr;
  logic [2:0]                ld_ch;

  assign rd_addr = {aline_index, step_cnt[2:0]};
  // Read data lags its address by one cycle, so LOAD step k stores channel k-1.
  assign ld_ch   = step_cnt[2:0] - 3'd1;

  always_ff @(posedge clk) begin
    if (tbl_wr_en) mem[{tbl_wr_aline, tbl_wr_ch}] <= tbl_wr_data;
    rd_q <= mem[rd_addr];
  end

  always_comb begin
    state_d          = state;
    input_delay_data = 1'b0;
    start_transmit   = 1'b0;
    next_aline       = 1'b0;
    listening        = 1'b0;
    frame_busy       = 1'b0;
    frame_done       = 1'b0;
    case (state)
      IDLE:    if (start_frame) state_d = LOAD;
      LOAD: begin
        frame_busy = 1'b1;
        if (step_cnt == load_last) state_d = REQ;
      end
      REQ: begin
        frame_busy       = 1'b1;
        input_delay_data = 1'b1;
        state_d          = SETTLE;
      end
      SETTLE: begin
        frame_busy = 1'b1;
        if (step_cnt == settle_last) state_d = FIRE;
      end
      FIRE: begin
        frame_busy     = 1'b1;
        start_transmit = 1'b1;
        state_d        = WAIT_TX;
      end
      WAIT_TX: begin
        frame_busy = 1'b1;
        if (transmit_complete) state_d = LISTEN;
      end
      LISTEN: begin
        frame_busy = 1'b1;
        listening  = 1'b1;
        if (listen_cnt == '0) state_d = NEXT;
      end
      NEXT: begin
        frame_busy = 1'b1;
        next_aline = 1'b1;
        state_d    = (aline_index >= num_lines_m1) ? DONE : LOAD;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      step_cnt    <= '0;
      listen_cnt  <= '0;
      aline_index <= '0;
      for (int unsigned i = 0; i < 8; i++) delay_q[i] <= '0;
    end else begin
      state <= state_d;

      if (state_d != state)                    step_cnt <= '0;
      else if (state == LOAD || state == SETTLE) step_cnt <= step_cnt + step_one;

      if (state == WAIT_TX && state_d == LISTEN)   listen_cnt <= listen_cycles;
      else if (state == LISTEN && listen_cnt != '0) listen_cnt <= listen_cnt - listen_one;

      if (state == IDLE && state_d == LOAD)      aline_index <= '0;
      else if (state == NEXT && state_d == LOAD) aline_index <= aline_index + aline_one;

      if (state == LOAD && step_cnt != '0 && !abort) delay_q[ld_ch] <= rd_q;
    end
  end

  assign delay_ch0 = delay_q[0];
  assign delay_ch1 = delay_q[1];
  assign delay_ch2 = delay_q[2];
  assign delay_ch3 = delay_q[3];
  assign delay_ch4 = delay_q[4];
  assign delay_ch5 = delay_q[5];
  assign delay_ch6 = delay_q[6];
  assign delay_ch7 = delay_q[7];

endmodule

// File: tb/tb_aline_sequencer.sv
// Directed self-checking bench for aline_sequencer with a behavioural
// transmit_fsm responder and a negedge event monitor.
module tb_aline_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_wr_en;
  logic [5:0]  tbl_wr_aline;
  logic [2:0]  tbl_wr_ch;
  logic [15:0] tbl_wr_data;
  logic        start_frame;
  logic        abort;
  logic [5:0]  num_lines_m1;
  logic [19:0] listen_cycles;
  logic        transmit_complete;
  logic [15:0] delay_ch0, delay_ch1, delay_ch2, delay_ch3;
  logic [15:0] delay_ch4, delay_ch5, delay_ch6, delay_ch7;
  logic        input_delay_data, start_transmit, next_aline;
  logic [5:0]  aline_index;
  logic        listening, frame_busy, frame_done;

  always #5 clk = ~clk;

  aline_sequencer #(
    .num_channels  (8),
    .count_num_bits(16),
    .num_alines    (64),
    .aline_bits    (6),
    .listen_bits   (20)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tbl_wr_en        (tbl_wr_en),
    .tbl_wr_aline     (tbl_wr_aline),
    .tbl_wr_ch        (tbl_wr_ch),
    .tbl_wr_data      (tbl_wr_data),
    .start_frame      (start_frame),
    .abort            (abort),
    .num_lines_m1     (num_lines_m1),
    .listen_cycles    (listen_cycles),
    .transmit_complete(transmit_complete),
    .delay_ch0        (delay_ch0),
    .delay_ch1        (delay_ch1),
    .delay_ch2        (delay_ch2),
    .delay_ch3        (delay_ch3),
    .delay_ch4        (delay_ch4),
    .delay_ch5        (delay_ch5),
    .delay_ch6        (delay_ch6),
    .delay_ch7        (delay_ch7),
    .input_delay_data (input_delay_data),
    .start_transmit   (start_transmit),
    .next_aline       (next_aline),
    .aline_index      (aline_index),
    .listening        (listening),
    .frame_busy       (frame_busy),
    .frame_done       (frame_done)
  );

  logic [15:0] dly [8];
  assign dly[0] = delay_ch0; assign dly[1] = delay_ch1;
  assign dly[2] = delay_ch2; assign dly[3] = delay_ch3;
  assign dly[4] = delay_ch4; assign dly[5] = delay_ch5;
  assign dly[6] = delay_ch6; assign dly[7] = delay_ch7;
  logic [127:0] dly_bus;
  assign dly_bus = {delay_ch7, delay_ch6, delay_ch5, delay_ch4,
                    delay_ch3, delay_ch2, delay_ch1, delay_ch0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: event counters, cycle stamps and delay snapshot at each REQ.
  int n_idd = 0, n_st = 0, n_na = 0, n_fd = 0, chg_err = 0;
  int idd_cyc = 0, st_cyc = 0, fd_cyc = 0;
  int run = 0, last_run = 0;
  int st_idx [128];
  logic [15:0]  snap [8];
  logic [127:0] prev_bus = '0;
  bit locked = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!frame_busy) locked = 1'b0;
    if (locked && dly_bus !== prev_bus) chg_err++;
    prev_bus = dly_bus;
    if (input_delay_data) begin
      n_idd++;
      idd_cyc = cyc;
      for (int k = 0; k < 8; k++) snap[k] = dly[k];
      locked = 1'b1;
    end
    if (start_transmit) begin
      if (n_st < 128) st_idx[n_st] = int'(aline_index);
      n_st++;
      st_cyc = cyc;
    end
    if (next_aline) begin
      n_na++;
      locked = 1'b0;
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc;
    end
    if (listening) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  // Transmit FSM stand-in: transmit_complete pulses tx_lat cycles after FIRE.
  int tx_lat   = 5;
  bit stray_en = 1'b0;
  initial begin
    transmit_complete = 1'b0;
    forever begin
      @(negedge clk);
      if (start_transmit) begin
        repeat (tx_lat) @(posedge clk);
        #1 transmit_complete = 1'b1;
        @(posedge clk);
        #1 transmit_complete = 1'b0;
        if (stray_en) begin
          @(posedge clk);
          #1 transmit_complete = 1'b1;
          @(posedge clk);
          #1 transmit_complete = 1'b0;
        end
      end
    end
  end

  int b_idd, b_st, b_na, b_fd, b_chg, start_cyc;

  task automatic take_base();
    b_idd = n_idd; b_st = n_st; b_na = n_na; b_fd = n_fd; b_chg = chg_err;
  endtask

  task automatic tbl_write(input int a, input int c, input int d);
    tbl_wr_en    = 1'b1;
    tbl_wr_aline = 6'(a);
    tbl_wr_ch    = 3'(c);
    tbl_wr_data  = 16'(d);
    @(posedge clk); #1;
    tbl_wr_en    = 1'b0;
  endtask

  task automatic pulse_start();
    start_cyc   = cyc;
    start_frame = 1'b1;
    @(posedge clk); #1;
    start_frame = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_busy && n < budget);
    check(tag, 32'(frame_busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; tbl_wr_en = 1'b0; tbl_wr_aline = '0; tbl_wr_ch = '0;
    tbl_wr_data = '0; start_frame = 1'b0; abort = 1'b0;
    num_lines_m1 = '0; listen_cycles = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_ctrl", 32'({input_delay_data, start_transmit, next_aline,
                           listening, frame_busy, frame_done}), 0);
    check("rst_idx", 32'(aline_index), 0);
    check("rst_dly_lo", dly_bus[31:0], 0);
    check("rst_dly_hi", dly_bus[127:96], 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single line with timing measurements.
    for (int c = 0; c < 8; c++) tbl_write(0, c, 10 * (c + 1));
    num_lines_m1 = 6'd0; listen_cycles = 20'd4; tx_lat = 5;
    take_base();
    pulse_start();
    wait_idle("t1_timeout", 200);
    for (int c = 0; c < 8; c++) check("t1_dly", 32'(snap[c]), 32'(10 * (c + 1)));
    check("t1_load_lat", idd_cyc - start_cyc, 10);
    check("t1_req_to_fire", st_cyc - idd_cyc, 4);
    check("t1_fire_to_done", fd_cyc - st_cyc, 12);
    check("t1_n_req", n_idd - b_idd, 1);
    check("t1_listen_len", last_run, 5);
    check("t1_n_next", n_na - b_na, 1);
    check("t1_n_done", n_fd - b_fd, 1);
    check("t1_busy_after", 32'(frame_busy), 0);

    // Whole table: line k channel c = 100*k + c.
    for (int k = 0; k < 64; k++)
      for (int c = 0; c < 8; c++) tbl_write(k, c, 100 * k + c);

    // Four lines, stray start_frame and stray transmit_complete mid-frame.
    num_lines_m1 = 6'd3; listen_cycles = 20'd2; tx_lat = 3; stray_en = 1'b1;
    take_base();
    pulse_start();
    begin
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!(listening && aline_index == 6'd2) && n < 300);
      check("t2_reach_line2", 32'(aline_index), 2);
    end
    @(posedge clk); #1 start_frame = 1'b1;
    @(posedge clk); #1 start_frame = 1'b0;
    wait_idle("t2_timeout", 400);
    stray_en = 1'b0;
    check("t2_n_fire", n_st - b_st, 4);
    check("t2_n_next", n_na - b_na, 4);
    check("t2_n_done", n_fd - b_fd, 1);
    for (int k = 0; k < 4; k++) check("t2_idx_seq", st_idx[b_st + k], k);
    check("t2_final_idx", 32'(aline_index), 3);
    check("t2_listen_len", last_run, 3);
    check("t2_dly_stable", chg_err - b_chg, 0);
    for (int c = 0; c < 8; c++) check("t2_dly_line3", 32'(snap[c]), 32'(300 + c));

    // Abort during the listen window of line 1.
    num_lines_m1 = 6'd3; listen_cycles = 20'd10; tx_lat = 2;
    take_base();
    pulse_start();
    begin
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!(listening && aline_index == 6'd1) && n < 300);
      check("t3_reach_line1", 32'(listening), 1);
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t3_listening", 32'(listening), 0);
    check("t3_busy", 32'(frame_busy), 0);
    for (int c = 0; c < 8; c++) check("t3_dly_hold", 32'(dly[c]), 32'(100 + c));
    repeat (30) @(posedge clk); #1;
    check("t3_n_next", n_na - b_na, 1);
    check("t3_n_done", n_fd - b_fd, 0);
    check("t3_n_fire", n_st - b_st, 2);
    check("t3_still_idle", 32'(frame_busy), 0);

    // Reset while waiting on transmit_complete, then replay line 0.
    num_lines_m1 = 6'd1; listen_cycles = 20'd3; tx_lat = 20;
    pulse_start();
    begin
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!start_transmit && n < 100);
      check("t4_reach_fire", 32'(start_transmit), 1);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t4_rst_ctrl", 32'({input_delay_data, start_transmit, next_aline,
                              listening, frame_busy, frame_done}), 0);
    check("t4_rst_idx", 32'(aline_index), 0);
    for (int c = 0; c < 8; c++) check("t4_rst_dly", 32'(dly[c]), 0);
    repeat (25) @(posedge clk); #1;
    num_lines_m1 = 6'd0; listen_cycles = 20'd1; tx_lat = 3;
    take_base();
    pulse_start();
    wait_idle("t4_timeout", 200);
    for (int c = 0; c < 8; c++) check("t4_replay_dly", 32'(snap[c]), 32'(c));
    check("t4_n_done", n_fd - b_fd, 1);

    // listen_cycles=0 and transmit_complete on the first WAIT_TX cycle.
    num_lines_m1 = 6'd0; listen_cycles = 20'd0; tx_lat = 1;
    take_base();
    pulse_start();
    wait_idle("t5_timeout", 200);
    check("t5_listen_len", last_run, 1);
    check("t5_fire_to_done", fd_cyc - st_cyc, 4);
    check("t5_n_done", n_fd - b_fd, 1);

    // Full 64-line frame.
    num_lines_m1 = 6'd63; listen_cycles = 20'd0; tx_lat = 1;
    take_base();
    pulse_start();
    wait_idle("t6_timeout", 3000);
    check("t6_n_fire", n_st - b_st, 64);
    begin
      int bad = 0;
      for (int k = 0; k < 64; k++) if (st_idx[b_st + k] != k) bad++;
      check("t6_idx_seq_errs", bad, 0);
    end
    check("t6_last_idx", st_idx[b_st + 63], 63);
    check("t6_final_idx", 32'(aline_index), 63);
    check("t6_n_done", n_fd - b_fd, 1);
    check("t6_dly_stable", chg_err - b_chg, 0);
    check("t6_dly_ch0", 32'(snap[0]), 6300);
    check("t6_dly_ch7", 32'(snap[7]), 6307);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
